// File: rtl/vram_pkg.sv
// Shared types and sizes for the four-port VRAM arbiter.
// Pure declarations; no logic or state.
package vram_pkg;

  localparam int NUM_VRAM_PORTS = 4;
  localparam int VRAM_ADDR_W    = 15;

  typedef logic [1:0]  vram_port_idx_t;
  typedef logic [31:0] vram_word_t;

  // Port index k positions after base, wrapping 3 -> 0.
  function automatic vram_port_idx_t vram_next_idx(input vram_port_idx_t base, input int k);
    return base + vram_port_idx_t'(k);
  endfunction

endpackage

// File: rtl/vram_rr_pick.sv
// Rotating-priority pick: first requester after last_idx, wrapping, wins.
// Purely combinational, zero latency; no backpressure (a grant is offered whenever any request is set).
module vram_rr_pick
  import vram_pkg::*;
(
  input  logic [NUM_VRAM_PORTS-1:0] req,
  input  vram_port_idx_t            last_idx,
  output logic [NUM_VRAM_PORTS-1:0] gnt_oh,
  output vram_port_idx_t            gnt_idx,
  output logic                      gnt_vld
);

  vram_port_idx_t cand;

  // Walk from lowest priority (last_idx itself) to highest so the closest requester is written last.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int k = NUM_VRAM_PORTS; k >= 1; k--) begin
      cand = vram_next_idx(last_idx, k);
      if (req[cand]) begin
        gnt_idx = cand;
        gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    if (gnt_vld) begin
      gnt_oh[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Work-conserving 4-port arbiter for a single-ported VRAM: grant in cycle N, registered ack and read data in N+1.
// Requesters hold strobe until ack; starvation bounded by per-port wait counters, port 3 has an urgency override.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W   = VRAM_ADDR_W,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic [ADDR_W-1:0] if0_addr,
  input  logic [31:0]       if0_wrdata,
  input  logic [3:0]        if0_wrbytesel,
  input  logic              if0_write,
  input  logic              if0_strobe,
  output logic              if0_ack,
  output logic [31:0]       if0_rddata,

  input  logic [ADDR_W-1:0] if1_addr,
  input  logic              if1_strobe,
  output logic              if1_ack,
  output logic [31:0]       if1_rddata,

  input  logic [ADDR_W-1:0] if2_addr,
  input  logic              if2_strobe,
  output logic              if2_ack,
  output logic [31:0]       if2_rddata,

  input  logic [ADDR_W-1:0] if3_addr,
  input  logic              if3_strobe,
  input  logic              if3_urgent,
  output logic              if3_ack,
  output logic [31:0]       if3_rddata,

  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wrdata,
  output logic [3:0]        ram_wrbytesel,
  output logic              ram_write,
  input  logic [31:0]       ram_rddata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = cnt_t'(MAX_WAIT);

  logic [NUM_VRAM_PORTS-1:0] strobe;
  logic [NUM_VRAM_PORTS-1:0] eligible;
  logic [ADDR_W-1:0]         port_addr [NUM_VRAM_PORTS];

  logic [NUM_VRAM_PORTS-1:0] ack_q, ack_d;
  vram_port_idx_t            last_grant_q, last_grant_d;
  cnt_t                      wait_cnt_q [NUM_VRAM_PORTS];
  cnt_t                      wait_cnt_d [NUM_VRAM_PORTS];

  logic [NUM_VRAM_PORTS-1:0] rr_gnt_oh;
  vram_port_idx_t            rr_gnt_idx;
  logic                      rr_gnt_vld;

  logic                      starve_hit;
  vram_port_idx_t            starve_idx;
  logic [NUM_VRAM_PORTS-1:0] gnt_oh;
  vram_port_idx_t            gnt_idx;
  logic                      gnt_vld;

  assign strobe       = {if3_strobe, if2_strobe, if1_strobe, if0_strobe};
  assign port_addr[0] = if0_addr;
  assign port_addr[1] = if1_addr;
  assign port_addr[2] = if2_addr;
  assign port_addr[3] = if3_addr;

  // The strobe is still held during its own ack cycle; that held strobe is not a new request.
  assign eligible = strobe & ~ack_q;

  vram_rr_pick u_rr_pick (
    .req      (eligible),
    .last_idx (last_grant_q),
    .gnt_oh   (rr_gnt_oh),
    .gnt_idx  (rr_gnt_idx),
    .gnt_vld  (rr_gnt_vld)
  );

  // Descending scan so the lowest-index saturated port is the one left standing.
  always_comb begin
    starve_hit = 1'b0;
    starve_idx = '0;
    for (int i = NUM_VRAM_PORTS - 1; i >= 0; i--) begin
      if (eligible[i] && (wait_cnt_q[i] == CNT_MAX)) begin
        starve_hit = 1'b1;
        starve_idx = vram_port_idx_t'(i);
      end
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    if (starve_hit) begin
      gnt_vld = 1'b1;
      gnt_idx = starve_idx;
      gnt_oh[starve_idx] = 1'b1;
    end else if (if3_urgent && eligible[3]) begin
      gnt_vld   = 1'b1;
      gnt_idx   = 2'd3;
      gnt_oh[3] = 1'b1;
    end else begin
      gnt_vld = rr_gnt_vld;
      gnt_idx = rr_gnt_idx;
      gnt_oh  = rr_gnt_oh;
    end
  end

  assign ram_addr      = gnt_vld ? port_addr[gnt_idx] : '0;
  assign ram_write     = rst_n && gnt_vld && (gnt_idx == 2'd0) && if0_write;
  assign ram_wrdata    = if0_wrdata;
  assign ram_wrbytesel = if0_wrbytesel;

  always_comb begin
    ack_d        = gnt_oh;
    last_grant_d = gnt_vld ? gnt_idx : last_grant_q;
    for (int i = 0; i < NUM_VRAM_PORTS; i++) begin
      wait_cnt_d[i] = '0;
      if (eligible[i] && !gnt_oh[i]) begin
        wait_cnt_d[i] = (wait_cnt_q[i] == CNT_MAX) ? CNT_MAX : wait_cnt_q[i] + cnt_t'(1);
      end
    end
  end

  // last_grant resets to 3 so that port 0 has first priority out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q        <= '0;
      last_grant_q <= 2'd3;
      for (int i = 0; i < NUM_VRAM_PORTS; i++) begin
        wait_cnt_q[i] <= '0;
      end
    end else begin
      ack_q        <= ack_d;
      last_grant_q <= last_grant_d;
      for (int i = 0; i < NUM_VRAM_PORTS; i++) begin
        wait_cnt_q[i] <= wait_cnt_d[i];
      end
    end
  end

  assign if0_ack = ack_q[0];
  assign if1_ack = ack_q[1];
  assign if2_ack = ack_q[2];
  assign if3_ack = ack_q[3];

  // Read data is shared; only the acked port treats it as valid.
  assign if0_rddata = ram_rddata;
  assign if1_rddata = ram_rddata;
  assign if2_rddata = ram_rddata;
  assign if3_rddata = ram_rddata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 1-cycle registered RAM.
module tb_vram_arbiter;

  logic        clk;
  logic        rst_n;
  logic [14:0] if0_addr, if1_addr, if2_addr, if3_addr;
  logic [31:0] if0_wrdata;
  logic [3:0]  if0_wrbytesel;
  logic        if0_write;
  logic        if0_strobe, if1_strobe, if2_strobe, if3_strobe;
  logic        if3_urgent;
  logic        if0_ack, if1_ack, if2_ack, if3_ack;
  logic [31:0] if0_rddata, if1_rddata, if2_rddata, if3_rddata;
  logic [14:0] ram_addr;
  logic [31:0] ram_wrdata;
  logic [3:0]  ram_wrbytesel;
  logic        ram_write;
  logic [31:0] ram_rddata;

  logic [3:0]  acks;
  assign acks = {if3_ack, if2_ack, if1_ack, if0_ack};

  int n_vec;
  int n_err;

  vram_arbiter #(.ADDR_W(15), .MAX_WAIT(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if0_addr      (if0_addr),
    .if0_wrdata    (if0_wrdata),
    .if0_wrbytesel (if0_wrbytesel),
    .if0_write     (if0_write),
    .if0_strobe    (if0_strobe),
    .if0_ack       (if0_ack),
    .if0_rddata    (if0_rddata),
    .if1_addr      (if1_addr),
    .if1_strobe    (if1_strobe),
    .if1_ack       (if1_ack),
    .if1_rddata    (if1_rddata),
    .if2_addr      (if2_addr),
    .if2_strobe    (if2_strobe),
    .if2_ack       (if2_ack),
    .if2_rddata    (if2_rddata),
    .if3_addr      (if3_addr),
    .if3_strobe    (if3_strobe),
    .if3_urgent    (if3_urgent),
    .if3_ack       (if3_ack),
    .if3_rddata    (if3_rddata),
    .ram_addr      (ram_addr),
    .ram_wrdata    (ram_wrdata),
    .ram_wrbytesel (ram_wrbytesel),
    .ram_write     (ram_write),
    .ram_rddata    (ram_rddata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM: byte-enabled write and registered read on the same edge.
  logic [31:0] mem [0:32767];
  logic        pre_en;
  logic [14:0] pre_addr;
  logic [31:0] pre_dat;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_dat;
    else if (ram_write) mem[ram_addr] <= merge(mem[ram_addr], ram_wrdata, ram_wrbytesel);
    ram_rddata <= mem[ram_addr];
  end

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    if0_strobe = 1'b0; if1_strobe = 1'b0; if2_strobe = 1'b0; if3_strobe = 1'b0;
    if0_write  = 1'b0; if3_urgent = 1'b0;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    clear_reqs();
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_addrs(input logic [14:0] base);
    if0_addr = base; if1_addr = base + 15'd1; if2_addr = base + 15'd2; if3_addr = base + 15'd3;
  endtask

  logic [1:0]  starve_seq [12];
  logic [14:0] exp_addr;
  logic [3:0]  exp_ack;
  logic [1:0]  g, g_prev;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    clear_reqs();
    set_addrs(15'h0000);
    if0_wrdata = '0; if0_wrbytesel = '0;
    pre_en = 1'b0; pre_addr = '0; pre_dat = '0;

    // Preload RAM while held in reset.
    step();
    pre_en = 1'b1; pre_addr = 15'h0123; pre_dat = 32'hDEADBEEF;
    step();
    pre_addr = 15'h7FFF; pre_dat = 32'h11223344;
    step();
    pre_en = 1'b0;

    // Reset state, write masked while in reset, port 0 first after release.
    @(negedge clk);
    check_vec("rst_acks", acks, 4'b0000);
    check_vec("rst_wr", ram_write, 1'b0);
    check_vec("rst_addr", ram_addr, 15'h0000);
    if0_addr = 15'h0040; if0_write = 1'b1; if0_strobe = 1'b1;
    #1;
    check_vec("rst_wr_mask", ram_write, 1'b0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check_vec("rel_wr", ram_write, 1'b1);
    check_vec("rel_addr", ram_addr, 15'h0040);
    step();
    clear_reqs();
    @(negedge clk);
    check_vec("rel_ack", acks, 4'b0001);

    // Single read on port 2.
    step();
    if2_addr = 15'h0123; if2_strobe = 1'b1;
    @(negedge clk);
    check_vec("rd_addr", ram_addr, 15'h0123);
    check_vec("rd_noack", acks, 4'b0000);
    step();
    @(negedge clk);
    check_vec("rd_ack", acks, 4'b0100);
    check_vec("rd_data", if2_rddata, 32'hDEADBEEF);
    check_vec("rd_no_regrant", ram_addr, 15'h0000);
    step();
    if2_strobe = 1'b0;
    @(negedge clk);
    check_vec("rd_ack_drop", acks, 4'b0000);

    // Round robin, all four ports.
    do_reset();
    set_addrs(15'h0010);
    if0_strobe = 1'b1; if1_strobe = 1'b1; if2_strobe = 1'b1; if3_strobe = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      g = 2'(c % 4);
      exp_addr = 15'h0010 + 15'(g);
      check_vec("rr_addr", ram_addr, exp_addr);
      exp_ack = (c == 0) ? 4'b0000 : (4'b0001 << ((c - 1) % 4));
      check_vec("rr_ack", acks, exp_ack);
      step();
    end
    clear_reqs();

    // Work-conserving: only ports 1 and 3.
    do_reset();
    set_addrs(15'h0010);
    if1_strobe = 1'b1; if3_strobe = 1'b1;
    g_prev = 2'd0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      g = (c % 2 == 0) ? 2'd1 : 2'd3;
      exp_addr = 15'h0010 + 15'(g);
      check_vec("wc_addr", ram_addr, exp_addr);
      exp_ack = (c == 0) ? 4'b0000 : (4'b0001 << g_prev);
      check_vec("wc_ack", acks, exp_ack);
      g_prev = g;
      step();
    end
    clear_reqs();

    // Byte-enabled write then read back through port 1.
    do_reset();
    if0_addr = 15'h7FFF; if0_wrdata = 32'hA5A5_5A5A; if0_wrbytesel = 4'b0101;
    if0_write = 1'b1; if0_strobe = 1'b1;
    @(negedge clk);
    check_vec("wr_en", ram_write, 1'b1);
    check_vec("wr_addr", ram_addr, 15'h7FFF);
    check_vec("wr_dat", ram_wrdata, 32'hA5A5_5A5A);
    check_vec("wr_sel", ram_wrbytesel, 4'b0101);
    step();
    @(negedge clk);
    check_vec("wr_once", ram_write, 1'b0);
    check_vec("wr_ack", acks, 4'b0001);
    step();
    if0_strobe = 1'b0; if0_write = 1'b0;
    if1_addr = 15'h7FFF; if1_strobe = 1'b1;
    @(negedge clk);
    check_vec("rb_addr", ram_addr, 15'h7FFF);
    check_vec("rb_nowr", ram_write, 1'b0);
    step();
    @(negedge clk);
    check_vec("rb_ack", acks, 4'b0010);
    check_vec("rb_data", if1_rddata, 32'h11A5_335A);
    step();
    clear_reqs();

    // Urgent port 3 starves port 0's neighbours until wait counters saturate.
    starve_seq = '{2'd3, 2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    set_addrs(15'h0020);
    if0_strobe = 1'b1; if1_strobe = 1'b1; if2_strobe = 1'b1; if3_strobe = 1'b1;
    if3_urgent = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      exp_addr = 15'h0020 + 15'(starve_seq[c]);
      check_vec("starve_addr", ram_addr, exp_addr);
      step();
    end
    clear_reqs();

    // Reset asserted during an ack; port 1 re-serviced right after release.
    do_reset();
    if1_addr = 15'h0030; if1_strobe = 1'b1;
    @(negedge clk);
    check_vec("mr_grant", ram_addr, 15'h0030);
    @(posedge clk);
    #2;
    check_vec("mr_ack", acks, 4'b0010);
    rst_n = 1'b0;
    #1;
    check_vec("mr_async_clr", acks, 4'b0000);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check_vec("mr_regrant", ram_addr, 15'h0030);
    step();
    @(negedge clk);
    check_vec("mr_reack", acks, 4'b0010);
    step();
    clear_reqs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Work-conserving arbiter that shares one single-ported VRAM (1-cycle registered read) among four requesters.
- Replaces fixed 4-slot TDM: idle slots go to the next waiting requester; display port 3 gets an urgency override; a per-port wait counter bounds latency.
- Sits between the bus/CPU port (0, only writer), the sprite/tile/display fetch ports (1-3) and the RAM macro.

Parameters:
- ADDR_W, 15, word address width (32-bit words).
- MAX_WAIT, 8, eligible-but-ungranted cycles after which a port is force-granted (≥1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- if0_addr  in  ADDR_W  port 0 word address
- if0_wrdata  in  32  port 0 write data
- if0_wrbytesel  in  4  port 0 byte enables
- if0_write  in  1  port 0 access is write
- if0_strobe  in  1  port 0 request, held until ack
- if0_ack  out  1  port 0 done; rddata valid this cycle
- if0_rddata  out  32  port 0 read data
- ifN_addr  in  ADDR_W  port N address (N=1..3, read-only)
- ifN_strobe  in  1  port N request (N=1..3)
- ifN_ack  out  1  port N done (N=1..3)
- ifN_rddata  out  32  port N read data (N=1..3)
- if3_urgent  in  1  display FIFO low; raise port 3 priority
- ram_addr  out  ADDR_W  RAM address
- ram_wrdata  out  32  = if0_wrdata
- ram_wrbytesel  out  4  = if0_wrbytesel
- ram_write  out  1  RAM write enable
- ram_rddata  in  32  RAM read data, valid 1 cycle after address

Behaviour:
- Eligible[i] = ifi_strobe && !ifi_ack; this masks the still-held strobe during its own ack cycle.
- One grant per cycle, combinational. Order:
  - (1) lowest-index port with wait_cnt[i]==MAX_WAIT and eligible;
  - (2) port 3 if if3_urgent and eligible;
  - (3) round-robin: first eligible port starting at last_grant+1, wrapping 3→0.
- Granted cycle N:
  - ram_addr = granted port's addr.
  - ram_write = 1 only if grant is port 0 and if0_write.
  - No grant: ram_addr = 0, ram_write = 0.
- Ack: ifi_ack registered, high exactly in cycle N+1, one cycle wide.
  - All ifi_rddata = ram_rddata combinationally; valid for the acked port in N+1.
  - Write ack also in N+1; write data is committed at the N edge.
- Throughput:
  - Back-to-back grants to different ports every cycle.
  - Same port at most every 2nd cycle.
  - A new request may be presented in the ack cycle; it becomes eligible in N+2.
- last_grant: updated only on a grant; held when idle.
- wait_cnt[i] (clog2(MAX_WAIT+1) bits):
  - cleared when granted or not eligible;
  - otherwise +1, saturating at MAX_WAIT.
- Simultaneous: several ports at MAX_WAIT → lowest index wins; the others keep saturated counts and win on following cycles.
- Reset values: all ifi_ack = 0; last_grant = 3 (port 0 first); wait_cnt = 0; ram_write = 0 while rst_n low.
- Reset mid-operation: acks clear immediately and in-flight accesses are dropped. Requesters keep strobe and are re-serviced after release. A write granted in the same cycle as reset assertion is not guaranteed.
- Requester rule, not checked: addr/wrdata/write stable while strobe high and before ack.

Decomposition:
- Package vram_pkg:
  - NUM_VRAM_PORTS = 4, VRAM_ADDR_W = 15;
  - typedef vram_port_idx_t (2 bits);
  - typedef vram_word_t (32 bits).
- Sub-module vram_rr_pick: 4-bit request vector + last index → one-hot grant + index + valid; combinational rotating priority encoder.
- Top holds the override mux, wait counters, ack registers and the RAM mux.

Test Plan:
- Single read: if2_strobe, addr 0x0123, RAM word 0xDEADBEEF → ram_addr=0x0123 in cycle N, if2_ack=1 with if2_rddata=0xDEADBEEF in N+1 only; if2 not re-granted in N+1.
- Round-robin: ports 0-3 strobe continuously, urgent=0 → grant order 0,1,2,3,0… repeating; each ack 1 cycle wide; no idle RAM cycles.
- Work-conserving: only ports 1 and 3 request → grants 1,3,1,3…; one grant per cycle; ports 0/2 never acked.
- Write: if0 write addr 0x7FFF, data 0xA5A5_5A5A, bytesel 4'b0101 → ram_write=1 for exactly one cycle; a port 1 readback returns the old word with bytes 0 and 2 replaced.
- Urgency/starvation: if3_urgent=1 with port 3 strobing every other cycle, port 1 waiting → port 1 is still granted no later than MAX_WAIT=8 cycles after becoming eligible.
- Reset: rst_n low while if1_ack=1 → ack drops asynchronously. After release with port 1 still strobing, port 0 idle → port 1 granted in the first cycle.
